// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-bank slave.
package apb_pkg;

  // Transfer FSM: IDLE waits for a setup phase, ACCESS runs the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // PSLVERR encodings.
  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  // Merge one byte lane: take the new byte when its strobe is set.
  function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                            input logic [7:0] wdata_byte,
                                            input logic       strb);
    return strb ? wdata_byte : old_byte;
  endfunction

  // Byte address to word index (shift = log2 of bytes per word).
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array with byte-strobe write port, read mux (reg 0 = ID) and flat output.
import apb_pkg::*;

module apb_reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [$clog2(NUM_REGS)-1:0]    idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_REGS);

  // Register 0 is the constant ID, so only 1..NUM_REGS-1 need storage.
  logic [DATA_WIDTH-1:0] mem_reg [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] merged_word;

  // Read mux; index 0 (and the write-merge base for it) returns the ID constant.
  always_comb begin
    rdata = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rdata = mem_reg[i];
    end
  end

  // Per-lane merge of the addressed word with the incoming write data.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged_word[gi*8 +: 8] = strb_merge(rdata[gi*8 +: 8], wdata[gi*8 +: 8], wstrb[gi]);
  end

  // Register storage: cleared on reset, updated with the merged word on a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) mem_reg[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) mem_reg[i] <= merged_word;
      end
    end
  end

  // Flat parallel view of every register for the owning logic.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    if (gi == 0) begin : g_id
      assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
    end else begin : g_reg
      assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = mem_reg[gi];
    end
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 slave: transfer FSM, wait-state counter, address decode and response gating.
import apb_pkg::*;

module apb_regbank_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSELx,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDX_W = $clog2(NUM_REGS);

  apb_state_e            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  latch_setup;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [NB-1:0]         pstrb_reg;

  logic [31:0]           index_full;
  logic [IDX_W-1:0]      index;
  logic                  misaligned, out_of_range, write_id, err;
  logic                  complete, bank_we;
  logic [DATA_WIDTH-1:0] bank_rdata;

  // Next state and wait counter; a setup phase always (re)starts a transfer.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    latch_setup = 1'b0;
    if (PSELx && !PENABLE) begin
      state_next  = ACCESS;
      cnt_next    = 4'(WAIT_STATES);
      latch_setup = 1'b1;
    end else if (state_reg == ACCESS) begin
      if (!PSELx) begin
        state_next = IDLE;               // master aborted the transfer
      end else if (cnt_reg != 4'd0) begin
        cnt_next = cnt_reg - 4'd1;       // stalled access cycle
      end else begin
        state_next = IDLE;               // completing access cycle
      end
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request on every setup phase so the access phase is self-contained.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      pstrb_reg  <= '0;
    end else if (latch_setup) begin
      paddr_reg  <= PADDR;
      pwrite_reg <= PWRITE;
      pwdata_reg <= PWDATA;
      pstrb_reg  <= PSTRB;
    end
  end

  // Address decode and error conditions on the latched request.
  always_comb begin
    index_full   = addr_to_index(32'(paddr_reg), SHIFT);
    index        = index_full[IDX_W-1:0];
    misaligned   = (32'(paddr_reg) & ((32'd1 << SHIFT) - 32'd1)) != 32'd0;
    out_of_range = index_full >= 32'(NUM_REGS);
    write_id     = pwrite_reg && (index_full == 32'd0);
    err          = misaligned || out_of_range || write_id;
  end

  // Completion is combinational so PREADY falls with reset or a dropped PSELx.
  assign complete = (state_reg == ACCESS) && PSELx && PENABLE && (cnt_reg == 4'd0);
  assign bank_we  = complete && pwrite_reg && !err;

  assign PREADY  = complete;
  assign PSLVERR = (complete && err) ? SLVERR : OKAY;
  assign PRDATA  = (complete && !err && !pwrite_reg) ? bank_rdata : '0;

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .we        (bank_we),
    .idx       (index),
    .wdata     (pwdata_reg),
    .wstrb     (pstrb_reg),
    .rdata     (bank_rdata),
    .regs_flat (regs_o)
  );

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench: three slaves (0, 3 and 2 wait states) on one shared APB bus.
module tb_apb_regbank_slave;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NR = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           psel [3] = '{1'b0, 1'b0, 1'b0};
  logic           penable = 1'b0;
  logic           pwrite = 1'b0;
  logic [AW-1:0]  paddr = '0;
  logic [DW-1:0]  pwdata = '0;
  logic [3:0]     pstrb = '0;
  logic           pready_w [3];
  logic [DW-1:0]  prdata_w [3];
  logic           pslverr_w [3];
  logic [NR*DW-1:0] regs_w [3];
  int             ws_tab [3] = '{0, 3, 2};

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WS = (gi == 1) ? 3 : (gi == 2) ? 2 : 0;
    apb_regbank_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .WAIT_STATES(WS),
      .ID_VALUE   (32'hA9B0_0001)
    ) u_dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .PSELx   (psel[gi]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PREADY  (pready_w[gi]),
      .PRDATA  (prdata_w[gi]),
      .PSLVERR (pslverr_w[gi]),
      .regs_o  (regs_w[gi])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int d, input int r);
    return regs_w[d][r*DW +: DW];
  endfunction

  // One APB transfer on slave d; expectation is queued at issue, checked at PREADY.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    exp_t e;
    int   waits;
    bit   done;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) psel[k] = (k == d);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1 penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pready_w[d]) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin
          chk({tag, " timeout"}, 32'(pready_w[d]), 32'd1);
          done = 1'b1;
        end
      end
    end
    e = sb.pop_front();
    $display("xfer %s dut=%0d wr=%0b addr=%h prdata=%h pslverr=%0b waits=%0d",
             tag, d, wr, addr, prdata_w[d], pslverr_w[d], waits);
    chk({tag, " rdata"}, prdata_w[d], e.rdata);
    chk({tag, " slverr"}, 32'(pslverr_w[d]), 32'(e.err));
    chk({tag, " waits"}, 32'(waits), 32'(ws_tab[d]));
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst pready d%0d", d), 32'(pready_w[d]), 32'd0);
      chk($sformatf("rst prdata d%0d", d), prdata_w[d], 32'd0);
      chk($sformatf("rst pslverr d%0d", d), 32'(pslverr_w[d]), 32'd0);
      chk($sformatf("rst reg1 d%0d", d), reg_of(d, 1), 32'd0);
    end

    // Zero-wait write then back-to-back read.
    xfer(0, 1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr1");
    xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd1");
    chk("regs_o reg1", reg_of(0, 1), 32'hDEAD_BEEF);

    // Byte strobes.
    xfer(0, 1'b1, 16'h0008, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "wr2");
    xfer(0, 1'b1, 16'h0008, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "wr2strb");
    bus_idle();
    @(negedge clk);
    chk("regs_o reg2 strb", reg_of(0, 2), 32'h11BB_33DD);
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "rd2");

    // Error responses.
    xfer(0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wrid");
    xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, 32'hA9B0_0001, 1'b0, "rdid");
    xfer(0, 1'b0, 16'h0040, 32'h0, 4'h0, 32'h0, 1'b1, "rdoor");
    xfer(0, 1'b1, 16'h0006, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wrmis");
    xfer(0, 1'b1, 16'h0004, 32'h0, 4'h0, 32'h0, 1'b0, "wrnostrb");
    xfer(0, 1'b0, 16'h003C, 32'h0, 4'h0, 32'h0, 1'b0, "rd15");
    bus_idle();
    @(negedge clk);
    chk("id after errs", reg_of(0, 0), 32'hA9B0_0001);
    chk("reg1 after errs", reg_of(0, 1), 32'hDEAD_BEEF);
    chk("reg2 after errs", reg_of(0, 2), 32'h11BB_33DD);
    chk("idle pready", 32'(pready_w[0]), 32'd0);
    chk("idle prdata", prdata_w[0], 32'd0);

    // Three wait states.
    xfer(1, 1'b0, 16'h0000, 32'h0, 4'h0, 32'hA9B0_0001, 1'b0, "ws3 rdid");
    xfer(1, 1'b1, 16'h003C, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0, "ws3 wr15");
    xfer(1, 1'b0, 16'h003C, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, "ws3 rd15");

    // Abort after one stalled access cycle (two wait states).
    xfer(2, 1'b1, 16'h0008, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "ws2 wr2");
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) psel[k] = (k == 2);
    penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort stall pready", 32'(pready_w[2]), 32'd0);
    @(posedge clk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort pready", 32'(pready_w[2]), 32'd0);
    chk("abort prdata", prdata_w[2], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort reg2", reg_of(2, 2), 32'hCAFE_F00D);
    xfer(2, 1'b0, 16'h0008, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "ws2 rd2");

    // Reset during the completing access cycle of a zero-wait write.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) psel[k] = (k == 0);
    penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    #1 chk("pre-reset pready", 32'(pready_w[0]), 32'd1);
    rst_n = 1'b0;
    #1 chk("reset pready async", 32'(pready_w[0]), 32'd0);
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post-reset reg1 d%0d", d), reg_of(d, 1), 32'd0);
      chk($sformatf("post-reset reg2 d%0d", d), reg_of(d, 2), 32'd0);
    end
    xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, 32'h0, 1'b0, "post-reset rd1");
    bus_idle();
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
